// File: rtl/calc_cmd_seq.sv
// Command FIFO and sequencer that feeds one calculator operation at a time and holds its result.
// Optional watchdog enabled by defining CALC_SEQ_TIMEOUT_EN.
module calc_cmd_seq #(
    parameter int          FIFO_DEPTH     = 4,
    parameter int          START_CYCLES   = 2,
    parameter logic [8:0]  IDLE_STATE     = 9'b000000001,
    parameter int          TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_mode,
    input  logic [31:0] cmd_x,
    input  logic [31:0] cmd_n,
    output logic        start,
    output logic [2:0]  mode,
    output logic [31:0] calculator_input,
    output logic [31:0] n_input,
    input  logic [8:0]  calc_state,
    input  logic [31:0] calc_result,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [2:0]  res_mode,
    output logic        res_err,
    output logic        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(START_CYCLES + 1);
    localparam int EW = 3 + 32 + 32;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || START_CYCLES < 1 || TIMEOUT_CYCLES < 1)
    begin : g_bad_param
        $error("calc_cmd_seq: illegal parameter value");
    end

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT_BUSY, S_WAIT_DONE, S_PUSH} state_t;

    state_t          state, next_state;
    logic [EW-1:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [SW-1:0]   start_cnt;
    logic            push, pop;
    logic            start_next, capture, timeout, wd_expired;

    // cmd_ready comes from the registered count only, so a same-cycle pop never frees a slot early
    assign cmd_ready = (count != CW'(FIFO_DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == S_IDLE) && (count != '0);
    assign res_valid = (state == S_PUSH);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {cmd_mode, cmd_x, cmd_n};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        start_next = 1'b0;
        capture    = 1'b0;
        timeout    = 1'b0;
        case (state)
            S_IDLE: if (count != '0) next_state = S_LOAD;
            S_LOAD: begin
                if (start_cnt != '0) start_next = 1'b1;
                else                 next_state = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (calc_state != IDLE_STATE) next_state = S_WAIT_DONE;
                else if (wd_expired) begin
                    timeout    = 1'b1;
                    next_state = S_PUSH;
                end
            end
            S_WAIT_DONE: begin
                if (calc_state == IDLE_STATE) begin
                    capture    = 1'b1;
                    next_state = S_PUSH;
                end else if (wd_expired) begin
                    timeout    = 1'b1;
                    next_state = S_PUSH;
                end
            end
            S_PUSH: if (res_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            start            <= 1'b0;
            start_cnt        <= '0;
            mode             <= '0;
            calculator_input <= '0;
            n_input          <= '0;
            res_data         <= '0;
            res_mode         <= '0;
        end else begin
            state <= next_state;
            start <= start_next;
            if (pop) begin
                {mode, calculator_input, n_input} <= fifo_mem[rd_ptr];
                start_cnt <= SW'(START_CYCLES);
            end else if (state == S_LOAD && start_cnt != '0) begin
                start_cnt <= start_cnt - SW'(1);
            end
            if (capture) begin
                res_data <= calc_result;
                res_mode <= mode;
            end else if (timeout) begin
                res_data <= 32'h7FC0_0000;
                res_mode <= mode;
            end
        end
    end

`ifdef CALC_SEQ_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd;
    logic          err_q;

    // reloaded every LOAD cycle, so it starts full on the first wait cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            wd    <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == S_LOAD)
                wd <= WW'(TIMEOUT_CYCLES - 1);
            else if ((state == S_WAIT_BUSY || state == S_WAIT_DONE) && wd != '0)
                wd <= wd - WW'(1);
            if (capture)      err_q <= 1'b0;
            else if (timeout) err_q <= 1'b1;
        end
    end
    assign wd_expired = (wd == '0);
    assign res_err    = err_q;
`else
    assign wd_expired = 1'b0;
    assign res_err    = 1'b0;
`endif

endmodule
